// File: rtl/fb_pkg.sv
// Shared types and default geometry for the framebuffer scanout engine.
package fb_pkg;

  localparam int unsigned FB_DATA_W   = 15;
  localparam int unsigned FB_ADDR_W   = 16;
  localparam int unsigned FB_H_ACTIVE = 256;
  localparam int unsigned FB_V_ACTIVE = 256;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } fb_state_t;

  // Pixel plus sideband as carried through the skid FIFO at default width
  typedef struct packed {
    logic [FB_DATA_W-1:0] data;
    logic                 sof;
    logic                 eol;
  } fb_pix_t;

endpackage

// File: rtl/fb_scanout_if.sv
// Pixel stream (valid/ready with start-of-frame / end-of-line sideband).
interface fb_scanout_if
  import fb_pkg::*;
#(
  parameter int unsigned DATA_W = FB_DATA_W
) ();

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_sof;
  logic              m_eol;

  modport master (output m_valid, output m_data, output m_sof, output m_eol, input m_ready);
  modport slave  (input m_valid, input m_data, input m_sof, input m_eol, output m_ready);

endinterface

// File: rtl/fb_skid_fifo.sv
// Two-entry shift FIFO; head entry is the registered output so the stream
// payload comes straight from flops.
module fb_skid_fifo
  import fb_pkg::*;
#(
  parameter int unsigned W = FB_DATA_W + 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [1:0]   occ
);

  logic [W-1:0] e1_q;

  // Caller guarantees no push into a full FIFO and no pop from an empty one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout  <= '0;
      e1_q  <= '0;
      occ   <= '0;
      valid <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) dout <= din;
          else             e1_q <= din;
          occ   <= occ + 2'd1;
          valid <= 1'b1;
        end
        2'b01: begin
          dout  <= e1_q;
          occ   <= occ - 2'd1;
          valid <= (occ == 2'd2);
        end
        2'b11: begin
          if (occ == 2'd2) begin
            dout <= e1_q;
            e1_q <= din;
          end else begin
            dout <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer read-side scanout: sweeps H_ACTIVE*V_ACTIVE addresses, absorbs the
// 1-cycle RAM latency and emits a valid/ready pixel stream. Option macro: FB_SCANOUT_BASE_EN.
module fb_scanout
  import fb_pkg::*;
#(
  parameter int unsigned DATA_W   = FB_DATA_W,
  parameter int unsigned ADDR_W   = FB_ADDR_W,
  parameter int unsigned H_ACTIVE = FB_H_ACTIVE,
  parameter int unsigned V_ACTIVE = FB_V_ACTIVE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_q,
`ifdef FB_SCANOUT_BASE_EN
  input  logic [ADDR_W-1:0] base_addr,
`endif
  fb_scanout_if.master      m_if
);

  localparam int unsigned XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int unsigned FW = DATA_W + 2;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  fb_state_t         state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] base_c;
  logic              busy_d, done_d;
  logic              inflight_q, inflight_d;
  logic              tag_sof_q, tag_sof_d;
  logic              tag_eol_q, tag_eol_d;
  logic              issue_c, pop_c;
  logic [2:0]        credit_c;
  logic [1:0]        occ;
  logic              fifo_valid;
  logic [FW-1:0]     fifo_dout;

`ifdef FB_SCANOUT_BASE_EN
  assign base_c = base_addr;
`else
  assign base_c = '0;
`endif

  assign pop_c    = fifo_valid & m_if.m_ready;
  // Entries already owned by the FIFO or the RAM pipe after this cycle's pop
  assign credit_c = 3'(occ) + 3'(inflight_q) - 3'(pop_c);

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    addr_d     = rd_addr;
    busy_d     = busy;
    done_d     = 1'b0;
    inflight_d = 1'b0;
    tag_sof_d  = tag_sof_q;
    tag_eol_d  = tag_eol_q;
    issue_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // frame_done cycle still counts as busy for start purposes
        if (start && !frame_done) begin
          state_d = ISSUE;
          x_d     = '0;
          y_d     = '0;
          addr_d  = base_c;
          busy_d  = 1'b1;
        end
      end
      ISSUE: begin
        issue_c = (credit_c < 3'd2);
        if (issue_c) begin
          inflight_d = 1'b1;
          tag_sof_d  = (x_q == '0) && (y_q == '0);
          tag_eol_d  = (x_q == X_LAST);
          addr_d     = rd_addr + ADDR_W'(1);
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) state_d = DRAIN;
            else               y_d     = y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      DRAIN: begin
        // Last pixel: nothing else queued or in the RAM pipe
        if (pop_c && (occ == 2'd1) && !inflight_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      rd_addr    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      inflight_q <= 1'b0;
      tag_sof_q  <= 1'b0;
      tag_eol_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      rd_addr    <= addr_d;
      busy       <= busy_d;
      frame_done <= done_d;
      inflight_q <= inflight_d;
      tag_sof_q  <= tag_sof_d;
      tag_eol_q  <= tag_eol_d;
    end
  end

  fb_skid_fifo #(.W(FW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight_q),
    .din   ({rd_q, tag_sof_q, tag_eol_q}),
    .pop   (pop_c),
    .dout  (fifo_dout),
    .valid (fifo_valid),
    .occ   (occ)
  );

  assign m_if.m_valid = fifo_valid;
  assign m_if.m_data  = fifo_dout[FW-1:2];
  assign m_if.m_sof   = fifo_dout[1];
  assign m_if.m_eol   = fifo_dout[0];

endmodule

// File: tb/tb_fb_scanout.sv
// Self-checking bench for fb_scanout (H=4, V=2) with a behavioural RAM and frame model.
module tb_fb_scanout;
  import fb_pkg::*;

  localparam int unsigned DW   = 15;
  localparam int unsigned AW   = 16;
  localparam int unsigned H    = 4;
  localparam int unsigned V    = 2;
  localparam int unsigned NPIX = H * V;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          busy;
  logic          frame_done;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_q;
`ifdef FB_SCANOUT_BASE_EN
  logic [AW-1:0] base_addr = '0;
`endif

  fb_scanout_if #(.DATA_W(DW)) sif ();

  fb_scanout #(.DATA_W(DW), .ADDR_W(AW), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .rd_addr    (rd_addr),
    .rd_q       (rd_q),
`ifdef FB_SCANOUT_BASE_EN
    .base_addr  (base_addr),
`endif
    .m_if       (sif.master)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    return DW'(32'(a) + 32'h100);
  endfunction

  // 1-cycle registered-read RAM
  always @(posedge clk) rd_q <= ram_word(rd_addr);

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame reference: pixel i of a frame based at b
  logic [AW-1:0] cur_base = '0;
  function automatic fb_pix_t exp_pix(input int idx);
    fb_pix_t p;
    p.data = DW'(((int'(cur_base) + idx) % 65536) + 256);
    p.sof  = (idx == 0);
    p.eol  = ((idx % int'(H)) == int'(H) - 1);
    return p;
  endfunction

  int      exp_idx  = 0;
  int      cyc      = 0;
  int      first_hs = -1;
  int      last_hs  = -1;
  bit      done_due = 1'b0;
  bit      hold_pend = 1'b0;
  fb_pix_t hold_w;
  bit      mon_on   = 1'b0;

  always @(negedge clk) begin
    fb_pix_t obs;
    cyc++;
    obs.data = sif.m_data;
    obs.sof  = sif.m_sof;
    obs.eol  = sif.m_eol;
    if (!rst_n) begin
      hold_pend = 1'b0;
      done_due  = 1'b0;
    end else if (mon_on) begin
      check("frame_done", 32'(frame_done), 32'(done_due));
      if (done_due) check("busy_after_done", 32'(busy), 0);
      done_due = 1'b0;
      if (hold_pend) begin
        check("hold_valid", 32'(sif.m_valid), 1);
        check("hold_payload", 32'(obs), 32'(hold_w));
      end
      hold_pend = 1'b0;
      if (sif.m_valid) check("busy_while_valid", 32'(busy), 1);
      if (sif.m_valid && sif.m_ready) begin
        if (exp_idx < int'(NPIX)) begin
          check($sformatf("pix%0d", exp_idx), 32'(obs), 32'(exp_pix(exp_idx)));
          if (exp_idx == 0) first_hs = cyc;
          last_hs = cyc;
          exp_idx++;
          if (exp_idx == int'(NPIX)) done_due = 1'b1;
        end else begin
          check("extra_pixel", 32'(sif.m_valid), 0);
        end
      end else if (sif.m_valid) begin
        hold_pend = 1'b1;
        hold_w    = obs;
      end
    end
  end

  // m_ready drivers: 0 always-1, 1 pattern 1,0,0,1, 2 random, 3 always-0
  int rdy_mode = 0;
  int pidx     = 0;
  initial sif.m_ready = 1'b0;
  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       sif.m_ready = 1'b1;
      1: begin sif.m_ready = (pidx % 4 == 0) || (pidx % 4 == 3); pidx++; end
      2:       sif.m_ready = ($urandom_range(0, 3) != 0);
      default: sif.m_ready = 1'b0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [AW-1:0] b);
    cur_base = b;
    exp_idx  = 0;
    first_hs = -1;
    last_hs  = -1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    @(negedge clk);
    while (!frame_done && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!frame_done) check("done_timeout", 32'(frame_done), 1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_busy"},  32'(busy), 0);
    check({pfx, "_done"},  32'(frame_done), 0);
    check({pfx, "_addr"},  32'(rd_addr), 0);
    check({pfx, "_valid"}, 32'(sif.m_valid), 0);
    check({pfx, "_data"},  32'(sif.m_data), 0);
    check({pfx, "_sof"},   32'(sif.m_sof), 0);
    check({pfx, "_eol"},   32'(sif.m_eol), 0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick();
    mon_on = 1'b1;

    // Full-rate frame with latency probe
    rdy_mode = 0;
    arm('0);
    pulse_start();
    @(negedge clk);
    check("lat_busy", 32'(busy), 1);
    check("lat_valid0", 32'(sif.m_valid), 0);
    @(negedge clk);
    check("lat_valid1", 32'(sif.m_valid), 0);
    check("lat_addr1", 32'(rd_addr), 1);
    @(negedge clk);
    check("lat_valid2", 32'(sif.m_valid), 1);
    wait_done(50);
    check("burst_span", 32'(last_hs - first_hs), 32'(NPIX - 1));
    check("pix_count_t1", 32'(exp_idx), 32'(NPIX));
    repeat (2) tick();

    // Stall pattern 1,0,0,1
    rdy_mode = 1;
    pidx = 0;
    arm('0);
    pulse_start();
    wait_done(100);
    check("pix_count_t2", 32'(exp_idx), 32'(NPIX));
    repeat (2) tick();

    // Back-pressure: credit limit holds reads at 2
    rdy_mode = 3;
    arm('0);
    pulse_start();
    repeat (10) @(negedge clk);
    check("stall_addr", 32'(rd_addr), 2);
    check("stall_valid", 32'(sif.m_valid), 1);
    rdy_mode = 0;
    wait_done(50);
    check("pix_count_t3", 32'(exp_idx), 32'(NPIX));
    repeat (2) tick();

    // Start while busy and in the frame_done cycle is ignored
    rdy_mode = 2;
    arm('0);
    pulse_start();
    repeat (4) tick();
    pulse_start();
    check("midframe_busy", 32'(busy), 1);
    wait_done(200);
    start = 1'b1;
    @(negedge clk);
    check("done_cycle_start_ignored", 32'(busy), 0);
    arm('0);
    @(negedge clk);
    check("late_start_taken", 32'(busy), 1);
    start = 1'b0;
    wait_done(200);
    check("pix_count_t4", 32'(exp_idx), 32'(NPIX));
    repeat (2) tick();

    // Reset mid-frame
    rdy_mode = 0;
    arm('0);
    pulse_start();
    begin
      int k = 0;
      while (exp_idx < 4 && k < 50) begin
        @(negedge clk);
        k++;
      end
      if (exp_idx < 4) check("pix3_timeout", 32'(exp_idx), 4);
    end
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_idle_busy", 32'(busy), 0);
    tick();
    arm('0);
    pulse_start();
    wait_done(50);
    check("pix_count_t5", 32'(exp_idx), 32'(NPIX));
    repeat (2) tick();

`ifdef FB_SCANOUT_BASE_EN
    // Base address wrapping past the top of the address space
    rdy_mode = 0;
    base_addr = 16'hFFFE;
    arm(16'hFFFE);
    pulse_start();
    @(negedge clk);
    check("base_addr0", 32'(rd_addr), 32'hFFFE);
    @(negedge clk);
    check("base_addr1", 32'(rd_addr), 32'hFFFF);
    @(negedge clk);
    check("base_addr2", 32'(rd_addr), 32'h0000);
    wait_done(50);
    check("base_addr_end", 32'(rd_addr), 32'h0006);
    check("pix_count_t6", 32'(exp_idx), 32'(NPIX));
    repeat (2) tick();
`endif

    // Randomised frames
    for (int f = 0; f < 6; f++) begin
      logic [AW-1:0] b;
      b = '0;
`ifdef FB_SCANOUT_BASE_EN
      b = AW'($urandom);
      base_addr = b;
`endif
      rdy_mode = 2;
      arm(b);
      pulse_start();
      wait_done(300);
      check($sformatf("pix_count_rnd%0d", f), 32'(exp_idx), 32'(NPIX));
      repeat ($urandom_range(1, 4)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
